// File: rtl/anubis_session_ctrl.sv
// Session controller for one Anubis transaction: capture block+key from the link receiver,
// start the core, and return the result to the remote board through the sync/ack handshake.
module anubis_session_ctrl #(
    parameter int DATA_W         = 128,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clk_w5,
    input  logic              reset_b,
    input  logic              rx_done,
    input  logic [DATA_W-1:0] rx_data,
    input  logic [DATA_W-1:0] rx_key,
    input  logic              rx_encrypt,
    input  logic              r_acknowledge,
    input  logic              tx_done,
    input  logic              core_done,
    input  logic [DATA_W-1:0] core_result,
    output logic              rx_en,
    output logic [DATA_W-1:0] core_text,
    output logic [DATA_W-1:0] core_key,
    output logic              core_encrypt,
    output logic              core_start,
    output logic              tx_en,
    output logic [DATA_W-1:0] tx_data,
    output logic              basys3_sync,
    output logic              basys3_ack,
    output logic              busy,
    output logic              timeout_err
);

    localparam int WDOG_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX_ACK  = 3'd1,
        ST_LOAD    = 3'd2,
        ST_RUN     = 3'd3,
        ST_SYNC    = 3'd4,
        ST_SEND    = 3'd5,
        ST_RELEASE = 3'd6
    } state_t;

    state_t state_r;
    state_t state_nxt;

    logic [SYNC_STAGES-1:0] rx_done_sync_r;
    logic [SYNC_STAGES-1:0] r_ack_sync_r;
    logic [SYNC_STAGES-1:0] tx_done_sync_r;
    logic                   rx_done_prev_r;
    logic                   tx_done_prev_r;
    logic                   rx_done_s;
    logic                   r_ack_s;
    logic                   tx_done_s;
    logic                   rx_done_rise_s;
    logic                   tx_done_rise_s;

    logic [WDOG_W-1:0]      wdog_cnt_r;
    logic [WDOG_W-1:0]      wdog_cnt_nxt;
    logic                   wdog_expired_s;
    logic                   wdog_count_en_s;
    logic                   timeout_s;

    logic                   latch_rx_s;
    logic                   latch_res_s;

    logic rx_en_r,       rx_en_nxt;
    logic core_start_r,  core_start_nxt;
    logic tx_en_r,       tx_en_nxt;
    logic sync_r,        sync_nxt;
    logic ack_r,         ack_nxt;
    logic busy_r,        busy_nxt;
    logic timeout_err_r, timeout_err_nxt;

    logic [DATA_W-1:0] core_text_r;
    logic [DATA_W-1:0] core_key_r;
    logic              core_encrypt_r;
    logic [DATA_W-1:0] tx_data_r;

    // Input synchronizers plus previous-value flops for edge detection.
    always_ff @(posedge clk_w5 or posedge reset_b) begin
        if (reset_b) begin
            rx_done_sync_r <= '0;
            r_ack_sync_r   <= '0;
            tx_done_sync_r <= '0;
            rx_done_prev_r <= 1'b0;
            tx_done_prev_r <= 1'b0;
        end else begin
            rx_done_sync_r <= {rx_done_sync_r[SYNC_STAGES-2:0], rx_done};
            r_ack_sync_r   <= {r_ack_sync_r[SYNC_STAGES-2:0], r_acknowledge};
            tx_done_sync_r <= {tx_done_sync_r[SYNC_STAGES-2:0], tx_done};
            rx_done_prev_r <= rx_done_s;
            tx_done_prev_r <= tx_done_s;
        end
    end

    assign rx_done_s      = rx_done_sync_r[SYNC_STAGES-1];
    assign r_ack_s        = r_ack_sync_r[SYNC_STAGES-1];
    assign tx_done_s      = tx_done_sync_r[SYNC_STAGES-1];
    assign rx_done_rise_s = rx_done_s & ~rx_done_prev_r;
    assign tx_done_rise_s = tx_done_s & ~tx_done_prev_r;

    assign wdog_expired_s  = (wdog_cnt_r == WDOG_LAST);
    assign wdog_count_en_s = (state_r != ST_IDLE) && (state_r != ST_LOAD);

    // Next-state and next-output decode; a regular transition always beats watchdog expiry.
    always_comb begin
        state_nxt       = state_r;
        rx_en_nxt       = rx_en_r;
        core_start_nxt  = 1'b0;
        tx_en_nxt       = tx_en_r;
        sync_nxt        = sync_r;
        ack_nxt         = ack_r;
        timeout_err_nxt = 1'b0;
        latch_rx_s      = 1'b0;
        latch_res_s     = 1'b0;
        timeout_s       = 1'b0;

        case (state_r)
            ST_IDLE: begin
                rx_en_nxt = 1'b1;
                if (rx_done_rise_s) begin
                    latch_rx_s = 1'b1;
                    rx_en_nxt  = 1'b0;
                    ack_nxt    = 1'b1;
                    state_nxt  = ST_RX_ACK;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RX_ACK: begin
                if (!rx_done_s) begin
                    ack_nxt        = 1'b0;
                    core_start_nxt = 1'b1;
                    state_nxt      = ST_LOAD;
                end else begin
                    timeout_s = wdog_expired_s;
                end
            end
            ST_LOAD: begin
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (core_done) begin
                    latch_res_s = 1'b1;
                    sync_nxt    = 1'b1;
                    state_nxt   = ST_SYNC;
                end else begin
                    timeout_s = wdog_expired_s;
                end
            end
            ST_SYNC: begin
                if (r_ack_s) begin
                    ack_nxt   = 1'b1;
                    tx_en_nxt = 1'b1;
                    state_nxt = ST_SEND;
                end else begin
                    timeout_s = wdog_expired_s;
                end
            end
            ST_SEND: begin
                if (tx_done_rise_s) begin
                    tx_en_nxt = 1'b0;
                    sync_nxt  = 1'b0;
                    ack_nxt   = 1'b0;
                    state_nxt = ST_RELEASE;
                end else begin
                    timeout_s = wdog_expired_s;
                end
            end
            ST_RELEASE: begin
                if (!r_ack_s) begin
                    rx_en_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    timeout_s = wdog_expired_s;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                rx_en_nxt = 1'b1;
                tx_en_nxt = 1'b0;
                sync_nxt  = 1'b0;
                ack_nxt   = 1'b0;
            end
        endcase

        // Expiry abandons the session; latched buses are deliberately left alone.
        if (timeout_s) begin
            state_nxt       = ST_IDLE;
            rx_en_nxt       = 1'b1;
            core_start_nxt  = 1'b0;
            tx_en_nxt       = 1'b0;
            sync_nxt        = 1'b0;
            ack_nxt         = 1'b0;
            timeout_err_nxt = 1'b1;
        end else begin
            timeout_err_nxt = 1'b0;
        end

        busy_nxt = (state_nxt != ST_IDLE);

        if (state_nxt != state_r) begin
            wdog_cnt_nxt = '0;
        end else if (wdog_count_en_s) begin
            wdog_cnt_nxt = wdog_cnt_r + WDOG_W'(1);
        end else begin
            wdog_cnt_nxt = '0;
        end
    end

    // FSM state, watchdog and handshake/enable output registers.
    always_ff @(posedge clk_w5 or posedge reset_b) begin
        if (reset_b) begin
            state_r       <= ST_IDLE;
            wdog_cnt_r    <= '0;
            rx_en_r       <= 1'b1;
            core_start_r  <= 1'b0;
            tx_en_r       <= 1'b0;
            sync_r        <= 1'b0;
            ack_r         <= 1'b0;
            busy_r        <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            state_r       <= state_nxt;
            wdog_cnt_r    <= wdog_cnt_nxt;
            rx_en_r       <= rx_en_nxt;
            core_start_r  <= core_start_nxt;
            tx_en_r       <= tx_en_nxt;
            sync_r        <= sync_nxt;
            ack_r         <= ack_nxt;
            busy_r        <= busy_nxt;
            timeout_err_r <= timeout_err_nxt;
        end
    end

    // Data latches: request on frame capture, result on core completion.
    always_ff @(posedge clk_w5 or posedge reset_b) begin
        if (reset_b) begin
            core_text_r    <= '0;
            core_key_r     <= '0;
            core_encrypt_r <= 1'b0;
            tx_data_r      <= '0;
        end else begin
            if (latch_rx_s) begin
                core_text_r    <= rx_data;
                core_key_r     <= rx_key;
                core_encrypt_r <= rx_encrypt;
            end
            if (latch_res_s) begin
                tx_data_r <= core_result;
            end
        end
    end

    assign rx_en        = rx_en_r;
    assign core_text    = core_text_r;
    assign core_key     = core_key_r;
    assign core_encrypt = core_encrypt_r;
    assign core_start   = core_start_r;
    assign tx_en        = tx_en_r;
    assign tx_data      = tx_data_r;
    assign basys3_sync  = sync_r;
    assign basys3_ack   = ack_r;
    assign busy         = busy_r;
    assign timeout_err  = timeout_err_r;

endmodule

// File: tb/tb_anubis_session_ctrl.sv
// Scoreboard bench for anubis_session_ctrl: frames and results are queued when driven and
// compared when core_start / basys3_sync appear.
module tb_anubis_session_ctrl;

    localparam int DW  = 128;
    localparam int SS  = 2;
    localparam int TMO = 100;

    logic          clk_w5 = 1'b0;
    logic          reset_b;
    logic          rx_done;
    logic [DW-1:0] rx_data;
    logic [DW-1:0] rx_key;
    logic          rx_encrypt;
    logic          r_acknowledge;
    logic          tx_done;
    logic          core_done;
    logic [DW-1:0] core_result;
    logic          rx_en;
    logic [DW-1:0] core_text;
    logic [DW-1:0] core_key;
    logic          core_encrypt;
    logic          core_start;
    logic          tx_en;
    logic [DW-1:0] tx_data;
    logic          basys3_sync;
    logic          basys3_ack;
    logic          busy;
    logic          timeout_err;

    int checks_cnt = 0;
    int errors_cnt = 0;
    int start_cnt  = 0;
    logic sync_prev = 1'b0;

    logic [2*DW:0] frame_q[$];
    logic [DW-1:0] result_q[$];

    anubis_session_ctrl #(
        .DATA_W(DW), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk_w5(clk_w5), .reset_b(reset_b), .rx_done(rx_done), .rx_data(rx_data),
        .rx_key(rx_key), .rx_encrypt(rx_encrypt), .r_acknowledge(r_acknowledge),
        .tx_done(tx_done), .core_done(core_done), .core_result(core_result),
        .rx_en(rx_en), .core_text(core_text), .core_key(core_key),
        .core_encrypt(core_encrypt), .core_start(core_start), .tx_en(tx_en),
        .tx_data(tx_data), .basys3_sync(basys3_sync), .basys3_ack(basys3_ack),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk_w5 = ~clk_w5;

    task automatic check_eq(input string tag, input logic [2*DW:0] obs, input logic [2*DW:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_w5);
        #1;
    endtask

    function automatic logic sig_sel(input int sel);
        case (sel)
            0:       return core_start;
            1:       return basys3_sync;
            2:       return basys3_ack & tx_en;
            3:       return timeout_err;
            4:       return ~tx_en;
            5:       return rx_en;
            6:       return basys3_ack;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input string tag, input int sel, input int limit, output int n);
        n = 0;
        while (!sig_sel(sel) && n < limit) begin
            tick();
            n++;
        end
        check_eq(tag, sig_sel(sel), 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_rx_en"}, rx_en, 1);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_start"}, core_start, 0);
        check_eq({tag, "_tx_en"}, tx_en, 0);
        check_eq({tag, "_sync"}, basys3_sync, 0);
        check_eq({tag, "_ack"}, basys3_ack, 0);
    endtask

    // Scoreboard monitor: compare on core_start pulses and basys3_sync rising edges.
    initial begin
        forever begin
            @(negedge clk_w5);
            if (core_start === 1'b1) begin
                start_cnt++;
                if (frame_q.size() > 0) check_eq("frame", {core_encrypt, core_key, core_text}, frame_q.pop_front());
                else check_eq("start_spurious", core_start, 0);
            end
            if (basys3_sync === 1'b1 && sync_prev === 1'b0) begin
                if (result_q.size() > 0) check_eq("result", tx_data, result_q.pop_front());
                else check_eq("sync_spurious", basys3_sync, 0);
            end
            sync_prev = basys3_sync;
        end
    end

    task automatic start_frame(input logic [DW-1:0] d, input logic [DW-1:0] k, input logic enc);
        int n;
        frame_q.push_back({enc, k, d});
        rx_data = d; rx_key = k; rx_encrypt = enc; rx_done = 1'b1;
        wait_sig("rx_ack", 6, 10, n);
        check_eq("busy_capture", busy, 1);
        check_eq("rx_en_capture", rx_en, 0);
        tick();
        rx_done = 1'b0; rx_data = ~d; rx_key = ~k; rx_encrypt = ~enc;
        wait_sig("core_start", 0, 10, n);
        tick();
        check_eq("start_one_cycle", core_start, 0);
    endtask

    task automatic finish_result(input logic [DW-1:0] r);
        result_q.push_back(r);
        core_result = r; core_done = 1'b1;
        tick();
        check_eq("sync_latency", basys3_sync, 1);
        core_done = 1'b0; core_result = ~r;
    endtask

    task automatic handshake();
        int n;
        r_acknowledge = 1'b1;
        wait_sig("ack_tx_en", 2, 10, n);
        check_eq("ack_latency_ok", (n <= SS + 1), 1);
        check_eq("busy_send", busy, 1);
        tx_done = 1'b1;
        wait_sig("tx_en_drop", 4, 10, n);
        check_eq("sync_drop", basys3_sync, 0);
        check_eq("ack_drop", basys3_ack, 0);
        tx_done = 1'b0;
        r_acknowledge = 1'b0;
        wait_sig("back_idle", 5, 10, n);
        check_eq("busy_idle", busy, 0);
    endtask

    initial begin
        int n;
        logic [DW-1:0] d1, k1, a5;
        d1 = 128'h00112233445566778899AABBCCDDEEFF;
        k1 = 128'h000102030405060708090A0B0C0D0E0F;
        a5 = {16{8'hA5}};
        reset_b = 1'b1; rx_done = 1'b0; rx_data = '0; rx_key = '0; rx_encrypt = 1'b0;
        r_acknowledge = 1'b0; tx_done = 1'b0; core_done = 1'b0; core_result = '0;
        repeat (3) tick();
        check_idle_outputs("reset");
        check_eq("reset_tmo", timeout_err, 0);
        check_eq("reset_text", core_text, 0);
        check_eq("reset_txd", tx_data, 0);
        reset_b = 1'b0;
        repeat (2) tick();

        // Encrypt transaction
        start_frame(d1, k1, 1'b1);
        finish_result(a5);
        check_eq("enc_tx_data", tx_data, a5);
        handshake();

        // Decrypt transaction
        start_frame(128'hFEDCBA98765432100123456789ABCDEF, 128'h0F0E0D0C0B0A09080706050403020100, 1'b0);
        check_eq("dec_mode", core_encrypt, 0);
        finish_result(128'h3C3C3C3C5A5A5A5A0F0F0F0FC3C3C3C3);
        handshake();

        // Watchdog in RUN: core_done withheld
        start_frame(128'h1111, 128'h2222, 1'b1);
        wait_sig("tmo_run", 3, 200, n);
        check_eq("tmo_run_cycles", n, TMO);
        check_eq("tmo_run_rx_en", rx_en, 1);
        check_eq("tmo_run_busy", busy, 0);
        tick();
        check_eq("tmo_run_pulse", timeout_err, 0);
        check_eq("tmo_run_text_kept", core_text, 128'h1111);

        // Watchdog in SYNC: r_acknowledge withheld
        start_frame(128'h3333, 128'h4444, 1'b0);
        finish_result(128'h5555);
        wait_sig("tmo_sync", 3, 200, n);
        check_eq("tmo_sync_cycles", n, TMO);
        check_idle_outputs("tmo_sync");
        check_eq("tmo_sync_txd_kept", tx_data, 128'h5555);
        tick();
        check_eq("tmo_sync_pulse", timeout_err, 0);

        // Spurious rx_done during RUN, spurious core_done during SYNC
        start_frame(128'h6666, 128'h7777, 1'b1);
        rx_data = d1; rx_key = k1; rx_encrypt = 1'b0; rx_done = 1'b1;
        repeat (4) tick();
        rx_done = 1'b0;
        repeat (4) tick();
        check_eq("spur_rx_busy", busy, 1);
        check_eq("spur_rx_ack", basys3_ack, 0);
        check_eq("spur_rx_frame", {core_encrypt, core_key, core_text}, {1'b1, 128'h7777, 128'h6666});
        finish_result(128'h8888);
        core_result = a5; core_done = 1'b1;
        repeat (2) tick();
        core_done = 1'b0;
        check_eq("spur_cd_txd", tx_data, 128'h8888);
        check_eq("spur_cd_sync", basys3_sync, 1);
        check_eq("spur_cd_tx_en", tx_en, 0);
        handshake();

        // Reset in SEND, then a clean frame
        start_frame(128'h9999, 128'hAAAA, 1'b0);
        finish_result(128'hBBBB);
        r_acknowledge = 1'b1;
        wait_sig("pre_reset_send", 2, 10, n);
        reset_b = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        check_eq("mid_reset_txd", tx_data, 0);
        check_eq("mid_reset_text", core_text, 0);
        r_acknowledge = 1'b0;
        repeat (2) tick();
        reset_b = 1'b0;
        repeat (2) tick();
        start_frame(d1, a5, 1'b1);
        finish_result(k1);
        handshake();

        check_eq("start_count", start_cnt, 7);
        check_eq("frame_q_empty", frame_q.size(), 0);
        check_eq("result_q_empty", result_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
